// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector MEM-stage data responder.
package vec_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BYTES     = 6;
    localparam int BYTE_W    = 8;
    localparam int DATA_W    = BYTES * BYTE_W;
    // Each word occupies an 8-byte slot; the byte counter fills the low bits.
    localparam int STRIDE_SH = 3;

endpackage

// File: rtl/data_mem_responder.sv
// Serializes one 48-bit MEM-stage load/store into byte accesses on a byte-wide
// synchronous RAM and stalls the pipeline until the one-cycle acknowledge.
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int BYTES  = 6,
    parameter int RAM_AW = ADDR_W + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memReqM,
    input  logic                 memWriteM,
    input  logic [ADDR_W-1:0]    addrM,
    input  logic [8*BYTES-1:0]   WDM,
    output logic [8*BYTES-1:0]   RD,
    output logic                 memAck,
    output logic                 stallM,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);
    import vec_mem_pkg::*;

    localparam int WORD_W = BYTE_W * BYTES;
    localparam int CNT_W  = STRIDE_SH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]   rd_q, rd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            asm_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            asm_q   <= asm_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        asm_d   = asm_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (memReqM) begin
                    addr_d  = addrM;
                    wdata_d = WDM;
                    we_d    = memWriteM;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                cnt_d = cnt_q + 1'b1;
                // Read data lags the address by one cycle, so byte cnt-1 arrives now.
                if (!we_q) begin
                    for (int k = 1; k < BYTES; k++) begin
                        if (cnt_q == CNT_W'(k))
                            asm_d[BYTE_W*(k-1) +: BYTE_W] = ram_rdata;
                    end
                end
                if (cnt_q == LAST)
                    state_d = we_q ? DONE : DRAIN;
            end
            DRAIN: begin
                asm_d[BYTE_W*(BYTES-1) +: BYTE_W] = ram_rdata;
                // RD only ever takes a complete word, loaded as DONE is entered.
                rd_d    = {ram_rdata, asm_q[WORD_W-BYTE_W-1:0]};
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_en    = (state_q == XFER);
        ram_we    = (state_q == XFER) && we_q;
        ram_addr  = RAM_AW'({addr_q, cnt_q});
        ram_wdata = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt_q == CNT_W'(k))
                ram_wdata = wdata_q[BYTE_W*k +: BYTE_W];
        end
    end

    assign memAck = (state_q == DONE);
    assign stallM = memReqM & ~memAck;
    assign RD     = rd_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte RAM model, word-level reference model,
// table vectors, hand-written corner sequences and randomized operations.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReqM;
    logic        memWriteM;
    logic [9:0]  addrM;
    logic [47:0] WDM;
    logic [47:0] RD;
    logic        memAck;
    logic        stallM;
    logic        ram_en;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .BYTES(6), .RAM_AW(13)) dut (
        .clk(clk), .rst(rst), .memReqM(memReqM), .memWriteM(memWriteM),
        .addrM(addrM), .WDM(WDM), .RD(RD), .memAck(memAck), .stallM(stallM),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Byte-wide synchronous RAM with access logs
    logic [7:0]  ram [0:8191];
    logic [20:0] wlog[$];
    logic [12:0] rlog[$];

    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we === 1'b1) begin
                ram[ram_addr] <= ram_wdata;
                wlog.push_back({ram_addr, ram_wdata});
            end else begin
                ram_rdata <= ram[ram_addr];
                rlog.push_back(ram_addr);
            end
        end
    end

    // Reference model: expected RAM contents and the word RD should hold
    logic [7:0]  ref_bytes [0:8191];
    logic [47:0] ref_rd;

    function automatic logic [47:0] ref_word(input logic [9:0] a);
        logic [47:0] w;
        for (int k = 0; k < 6; k++) w[8*k +: 8] = ref_bytes[int'(a)*8 + k];
        return w;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            lat++;
            if (memAck === 1'b1) begin
                check("stall_at_ack", 64'(stallM), 64'd0);
                return;
            end
            check("stall_hold", 64'(stallM), 64'd1);
            if (ram_en === 1'b1) begin
                addrM     = 10'($urandom);
                WDM       = {16'($urandom), $urandom};
                memWriteM = 1'($urandom);
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [9:0] a, input logic [47:0] wd,
                          input bit start_now, output int lat, output logic [47:0] rd);
        int exp_lat;
        if (!start_now) @(negedge clk);
        wlog.delete();
        rlog.delete();
        memReqM = 1'b1; memWriteM = we; addrM = a; WDM = wd;
        wait_ack(lat);
        rd = RD;
        exp_lat = (we ? 7 : 8) + (start_now ? 1 : 0);
        check(we ? "store_latency" : "load_latency", 64'(lat), 64'(exp_lat));
        if (we) begin
            check("store_nwrites", 64'(wlog.size()), 64'd6);
            for (int k = 0; k < wlog.size() && k < 6; k++) begin
                check("store_addr", 64'(wlog[k][20:8]), 64'(int'(a)*8 + k));
                check("store_byte", 64'(wlog[k][7:0]), 64'(wd[8*k +: 8]));
            end
            for (int k = 0; k < 6; k++) ref_bytes[int'(a)*8 + k] = wd[8*k +: 8];
        end else begin
            check("load_nwrites", 64'(wlog.size()), 64'd0);
            check("load_nreads", 64'(rlog.size()), 64'd6);
            for (int k = 0; k < rlog.size() && k < 6; k++)
                check("load_addr", 64'(rlog[k]), 64'(int'(a)*8 + k));
            ref_rd = ref_word(a);
        end
        check("rd_model", 64'(rd), 64'(ref_rd));
        memReqM = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [47:0] wd;
        logic [47:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          lat;
        logic [47:0] rd, hold_rd;
        logic        rwe;
        logic [9:0]  ra;

        for (int i = 0; i < 8192; i++) begin
            ram[i] = 8'h00;
            ref_bytes[i] = 8'h00;
        end
        ref_rd    = '0;
        ram_rdata = '0;

        // Reset held with a store request pending
        rst = 1'b0; memReqM = 1'b1; memWriteM = 1'b1; addrM = 10'd5; WDM = 48'h665544332211;
        repeat (3) @(negedge clk);
        check("rst_rd", 64'(RD), 64'd0);
        check("rst_ack", 64'(memAck), 64'd0);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_stall", 64'(stallM), 64'd1);
        rst = 1'b1;
        wlog.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("st_en", 64'(ram_en), 64'd1);
            check("st_we", 64'(ram_we), 64'd1);
            check("st_addr", 64'(ram_addr), 64'(40 + k));
            check("st_wdata", 64'(ram_wdata), 64'(8'((k + 1) * 17)));
            check("st_stall", 64'(stallM), 64'd1);
        end
        @(negedge clk);
        check("st_ack", 64'(memAck), 64'd1);
        check("st_stall_fall", 64'(stallM), 64'd0);
        memReqM = 1'b0;
        check("st_nwrites", 64'(wlog.size()), 64'd6);
        for (int k = 0; k < 6; k++) ref_bytes[40 + k] = 8'((k + 1) * 17);
        @(negedge clk);
        check("st_ack_pulse", 64'(memAck), 64'd0);

        // Load after store, then a store must leave RD alone
        run_op(1'b0, 10'd5, 48'h0, 1'b0, lat, rd);
        check("ld_rd", 64'(rd), 64'h665544332211);

        tbl[0] = '{1'b1, 10'd12, 48'h0123456789AB, 48'h665544332211, 7};
        tbl[1] = '{1'b1, 10'd13, 48'hA5A55A5AF00F, 48'h665544332211, 7};
        tbl[2] = '{1'b0, 10'd12, 48'h0,            48'h0123456789AB, 8};
        tbl[3] = '{1'b0, 10'd13, 48'h0,            48'hA5A55A5AF00F, 8};
        tbl[4] = '{1'b1, 10'd12, 48'hFFFFFFFFFFFF, 48'hA5A55A5AF00F, 7};
        tbl[5] = '{1'b0, 10'd12, 48'h0,            48'hFFFFFFFFFFFF, 8};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0, lat, rd);
            check("tbl_rd", 64'(rd), 64'(tbl[i].exp_rd));
            check("tbl_lat", 64'(lat), 64'(tbl[i].exp_lat));
        end

        // Back-to-back: store request presented in the IDLE cycle after DONE
        run_op(1'b0, 10'd1, 48'h0, 1'b0, lat, rd);
        run_op(1'b1, 10'd2, 48'h0BADC0FFEE42, 1'b1, lat, rd);
        run_op(1'b0, 10'd2, 48'h0, 1'b0, lat, rd);
        check("b2b_rd", 64'(rd), 64'h0BADC0FFEE42);

        // Reset in the middle of a store at cnt=3
        run_op(1'b1, 10'd7, 48'h112233445566, 1'b0, lat, rd);
        @(negedge clk);
        wlog.delete();
        memReqM = 1'b1; memWriteM = 1'b1; addrM = 10'd7; WDM = 48'hAABBCCDDEEFF;
        repeat (4) @(negedge clk);
        check("mid_addr", 64'(ram_addr), 64'd59);
        rst = 1'b0;
        #1;
        check("mid_en", 64'(ram_en), 64'd0);
        check("mid_we", 64'(ram_we), 64'd0);
        check("mid_rd", 64'(RD), 64'd0);
        memReqM = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_nwrites", 64'(wlog.size()), 64'd3);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) ref_bytes[56 + k] = 8'(48'hAABBCCDDEEFF >> (8 * k));
        ref_rd = '0;
        run_op(1'b0, 10'd7, 48'h0, 1'b0, lat, rd);
        check("mid_load", 64'(rd), 64'h112233DDEEFF);

        // Top-of-memory word
        run_op(1'b1, 10'h3FF, 48'hCAFEBEEF1234, 1'b0, lat, rd);
        run_op(1'b0, 10'h3FF, 48'h0, 1'b0, lat, rd);
        check("wrap_first_addr", 64'(rlog.size() > 0 ? rlog[0] : 13'h0), 64'h1FF8);
        check("wrap_last_addr", 64'(rlog.size() > 5 ? rlog[5] : 13'h0), 64'h1FFD);
        check("wrap_rd", 64'(rd), 64'hCAFEBEEF1234);

        // Idle: no request, no RAM activity, RD stable
        hold_rd = RD;
        rlog.delete();
        wlog.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_en", 64'(ram_en), 64'd0);
            check("idle_stall", 64'(stallM), 64'd0);
            check("idle_rd", 64'(RD), 64'(hold_rd));
        end
        check("idle_accesses", 64'(rlog.size() + wlog.size()), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rwe = 1'($urandom);
            ra  = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
            run_op(rwe, ra, {16'($urandom), $urandom}, 1'b0, lat, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the vector pipeline MEM stage. Serves the data word that the MEM/WB register captures as ReadData.
- Accepts one 48-bit load or store request from the MEM stage at a time.
- Serializes each request into byte accesses on a byte-wide synchronous data RAM, assembling 48-bit load data from bytes.
- Holds the MEM stage with a stall until it pulses an acknowledge.

Parameters:
- ADDR_W, 10, word-address width from the MEM stage.
- BYTES, 6, bytes per vector word; DATA_W = 8*BYTES = 48.
- RAM_AW, ADDR_W+3, RAM byte-address width (8-byte stride per word).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- memReqM  in  1  MEM stage has a memory operation.
- memWriteM  in  1  1 = store, 0 = load; valid with memReqM.
- addrM  in  ADDR_W  word address.
- WDM  in  48  store data.
- RD  out  48  load data to MEM/WB register.
- memAck  out  1  one-cycle completion pulse.
- stallM  out  1  freeze pipeline up to and including MEM.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; valid one cycle after the read-enable edge.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, RD=0, memAck=0.
  - Latched addr/wdata/we = 0.
  - ram_en=0, ram_we=0.
- Reset mid-operation aborts the access immediately. No further RAM writes occur. Bytes already written stay written. RD is cleared.
- FSM states: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If memReqM=1: latch addrM, WDM, memWriteM; set cnt<=0; go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - ram_en=1, ram_we=we_q.
  - ram_addr={addr_q, cnt[2:0]}, ram_wdata=wdata_q[8*cnt +: 8].
  - cnt increments each cycle.
  - When cnt==BYTES-1: go to DONE if store, DRAIN if load.
- DRAIN (load only): ram_en=0; capture the final byte; go to DONE.
- Load capture: in every XFER cycle with cnt>0 and in DRAIN, RD_asm[8*(cnt-1) +: 8] <= ram_rdata. In DRAIN the index is BYTES-1.
- DONE:
  - memAck=1 for exactly one cycle.
  - On a load, RD updates to the assembled word at the DONE-entry edge, so RD is valid during DONE.
  - Go to IDLE.
- RD holding rules:
  - RD holds its value until the next load completes.
  - Stores never modify RD.
  - RD never shows partially assembled data.
- Byte order: little-endian. Byte k = WD[8k+7:8k] at byte address word*8+k. Bytes 6 and 7 of each 8-byte slot are never accessed.
- ram_* outputs decode combinationally from registered state and cnt only; no input-to-output paths. ram_en=0 in IDLE and DONE.
- stallM = memReqM & ~memAck. This is the only combinational input-to-output path.
- Timing (cycle 0 = IDLE cycle with memReqM=1):
  - Store: XFER in cycles 1-6, memAck in cycle 7.
  - Load: XFER in cycles 1-6, DRAIN in cycle 7, memAck in cycle 8.
- Request rules:
  - Request inputs are ignored outside IDLE; the latched copy is used.
  - memReqM=1 in the IDLE cycle after DONE is a new request, matching back-to-back pipeline operations.
  - memReqM=0 in IDLE: no RAM activity, stallM=0.
- Address wrap: addr_q all-ones maps to top RAM bytes. No overflow into other words, since cnt only modifies bits [2:0].

Decomposition:
- Shared package vec_mem_pkg holds:
  - state enum (IDLE, XFER, DRAIN, DONE);
  - constants BYTES=6, DATA_W=48, BYTE_W=8;
  - localparam for the word-to-byte stride shift (3).
- Single module; no sub-module required. The byte assembler stays inline.

Test Plan:
- Reset: hold rst=0 with memReqM=1 -> RD=0, memAck=0, ram_en=0, stallM=1. Release reset -> store begins in XFER on the next cycle.
- Store: addrM=5, WDM=48'h665544332211 -> cycles 1-6 write bytes 11,22,33,44,55,66 to ram_addr 40..45 with ram_we=1. memAck in cycle 7; stallM falls with memAck.
- Load after store: addrM=5 -> reads at 40..45, DRAIN in cycle 7, memAck in cycle 8, RD=48'h665544332211. RD unchanged by a following store.
- Back-to-back: load addr 1 then memReqM held high for store addr 2 in the IDLE cycle after DONE -> second XFER starts the next cycle. RAM writes never overlap.
- Mid-op reset: assert rst=0 during a store at cnt=3 -> only bytes 0-2 written, FSM in IDLE, no further ram_we. A subsequent load shows the old bytes 3-5.
- Wrap/idle: addrM=10'h3FF load -> ram_addr 13'h1FF8..1FFD. Idle with memReqM=0 for 20 cycles -> ram_en=0, stallM=0, RD stable.
